// File: rtl/axis_packet_mux.sv
// axis_packet_mux
//
// N-to-1 AXI-Stream packet multiplexer feeding one ring ingress port. Sources are
// arbitrated round-robin at packet granularity: a winner owns the output until its
// tlast beat is accepted. Accepted beats go through a 2-entry output FIFO, so every
// m_* output comes from a register and a packet streams at one beat per cycle.
//
// Optional feature: define AXIS_PACKET_MUX_SRC_TAG_EN to replace m_tid with the
// index of the source that produced the beat (s_tid is then ignored).
//
// Ports
//   clk_usr        user clock, rising edge
//   rst_usr_sync   synchronous active-high reset, flushes the FIFO
//   s_tvalid/s_tready/s_tdata/s_tlast/s_tid/s_tdest   per-source slave AXI-S
//   m_tvalid/m_tready/m_tdata/m_tlast/m_tid/m_tdest   master AXI-S to the ring
//   grant_idx      current or most recent packet owner (debug)
module axis_packet_mux #(
    parameter int unsigned NUM_INPUTS  = 4,
    parameter int unsigned TID_WIDTH   = 2,
    parameter int unsigned TDEST_WIDTH = 4,
    parameter int unsigned TDATA_WIDTH = 512
) (
    input  logic                          clk_usr,
    input  logic                          rst_usr_sync,
    input  logic [NUM_INPUTS-1:0]         s_tvalid,
    output logic [NUM_INPUTS-1:0]         s_tready,
    input  logic [TDATA_WIDTH-1:0]        s_tdata [NUM_INPUTS],
    input  logic [NUM_INPUTS-1:0]         s_tlast,
    input  logic [TID_WIDTH-1:0]          s_tid   [NUM_INPUTS],
    input  logic [TDEST_WIDTH-1:0]        s_tdest [NUM_INPUTS],
    output logic                          m_tvalid,
    input  logic                          m_tready,
    output logic [TDATA_WIDTH-1:0]        m_tdata,
    output logic                          m_tlast,
    output logic [TID_WIDTH-1:0]          m_tid,
    output logic [TDEST_WIDTH-1:0]        m_tdest,
    output logic [$clog2(NUM_INPUTS)-1:0] grant_idx
);

    localparam int unsigned IdxW = $clog2(NUM_INPUTS);
    typedef logic [IdxW-1:0] idx_t;

    typedef enum logic {StIdle, StLocked} state_e;

    state_e     state_q;
    idx_t       grant_q;
    idx_t       last_grant_q;

    logic [1:0] count_q;
    logic       rd_ptr_q;
    logic       wr_ptr_q;

    logic [TDATA_WIDTH-1:0] buf_data_q [2];
    logic [1:0]             buf_last_q;
    logic [TID_WIDTH-1:0]   buf_id_q   [2];
    logic [TDEST_WIDTH-1:0] buf_dest_q [2];

    idx_t                   pick;
    logic                   pick_found;
    logic                   push;
    logic                   pop;
    logic [TID_WIDTH-1:0]   push_id;

    function automatic idx_t wrap_idx(idx_t base, int unsigned off);
        return idx_t'((32'(base) + off) % NUM_INPUTS);
    endfunction

    // First valid source scanning upward from the one after the previous winner.
    always_comb begin
        pick       = last_grant_q;
        pick_found = 1'b0;
        for (int unsigned k = 1; k <= NUM_INPUTS; k++) begin
            if (!pick_found && s_tvalid[wrap_idx(last_grant_q, k)]) begin
                pick       = wrap_idx(last_grant_q, k);
                pick_found = 1'b1;
            end
        end
    end

    // Ready depends only on registered state, never on s_tvalid or m_tready.
    always_comb begin
        s_tready = '0;
        if (state_q == StLocked && count_q != 2'd2) begin
            s_tready[grant_q] = 1'b1;
        end
    end

    assign push = s_tvalid[grant_q] & s_tready[grant_q];
    assign pop  = m_tvalid & m_tready;

`ifdef AXIS_PACKET_MUX_SRC_TAG_EN
    if (TID_WIDTH < $clog2(NUM_INPUTS)) begin : g_tid_too_narrow
        $error("axis_packet_mux: TID_WIDTH too narrow to carry the source index");
    end

    // Tag is captured per beat so a queued beat keeps its source after a new grant.
    assign push_id = TID_WIDTH'(grant_q);

    logic unused_tid;
    always_comb begin
        unused_tid = 1'b0;
        for (int i = 0; i < int'(NUM_INPUTS); i++) begin
            unused_tid = unused_tid ^ (^s_tid[i]);
        end
    end
`else
    assign push_id = s_tid[grant_q];
`endif

    always_ff @(posedge clk_usr) begin
        if (rst_usr_sync) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            last_grant_q <= idx_t'(NUM_INPUTS - 1);
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pick_found) begin
                        grant_q      <= pick;
                        last_grant_q <= pick;
                        state_q      <= StLocked;
                    end
                end
                StLocked: begin
                    if (push && s_tlast[grant_q]) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_usr) begin
        if (rst_usr_sync) begin
            count_q    <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            buf_last_q <= '0;
            for (int i = 0; i < 2; i++) begin
                buf_data_q[i] <= '0;
                buf_id_q[i]   <= '0;
                buf_dest_q[i] <= '0;
            end
        end else begin
            if (push) begin
                buf_data_q[wr_ptr_q] <= s_tdata[grant_q];
                buf_last_q[wr_ptr_q] <= s_tlast[grant_q];
                buf_id_q[wr_ptr_q]   <= push_id;
                buf_dest_q[wr_ptr_q] <= s_tdest[grant_q];
                wr_ptr_q             <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign m_tvalid  = (count_q != 2'd0);
    assign m_tdata   = buf_data_q[rd_ptr_q];
    assign m_tlast   = buf_last_q[rd_ptr_q];
    assign m_tid     = buf_id_q[rd_ptr_q];
    assign m_tdest   = buf_dest_q[rd_ptr_q];
    assign grant_idx = grant_q;

endmodule

// File: tb/tb_axis_packet_mux.sv
`timescale 1ns/1ps
module tb_axis_packet_mux;

    localparam int NI   = 4;
    localparam int TIDW = 2;
    localparam int TDW  = 4;
    localparam int DW   = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [NI-1:0]   s_tvalid, s_tready, s_tlast;
    logic [DW-1:0]   s_tdata [NI];
    logic [TIDW-1:0] s_tid   [NI];
    logic [TDW-1:0]  s_tdest [NI];
    logic            m_tvalid, m_tready, m_tlast;
    logic [DW-1:0]   m_tdata;
    logic [TIDW-1:0] m_tid;
    logic [TDW-1:0]  m_tdest;
    logic [1:0]      grant_idx;

    axis_packet_mux #(
        .NUM_INPUTS (NI),
        .TID_WIDTH  (TIDW),
        .TDEST_WIDTH(TDW),
        .TDATA_WIDTH(DW)
    ) dut (
        .clk_usr     (clk),
        .rst_usr_sync(rst),
        .s_tvalid    (s_tvalid),
        .s_tready    (s_tready),
        .s_tdata     (s_tdata),
        .s_tlast     (s_tlast),
        .s_tid       (s_tid),
        .s_tdest     (s_tdest),
        .m_tvalid    (m_tvalid),
        .m_tready    (m_tready),
        .m_tdata     (m_tdata),
        .m_tlast     (m_tlast),
        .m_tid       (m_tid),
        .m_tdest     (m_tdest),
        .grant_idx   (grant_idx)
    );

    typedef struct {
        logic [DW-1:0]   data;
        logic            last;
        logic [TIDW-1:0] tid;
        logic [TDW-1:0]  dest;
        int              cyc;
    } beat_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- source side ----------------
    beat_t         src_q [NI][$];
    int            seq_cnt [NI];
    int            valid_pct = 100;
    int            rdy_pct   = 100;
    logic [NI-1:0] drv_acc;

    task automatic load_pkt(input int src, input int len, input logic [TIDW-1:0] tid_fixed,
                            input bit rand_tid);
        for (int b = 0; b < len; b++) begin
            beat_t x;
            x.data = {8'(src), 24'(seq_cnt[src])};
            seq_cnt[src]++;
            x.last = (b == len - 1);
            x.tid  = rand_tid ? TIDW'($urandom) : tid_fixed;
            x.dest = TDW'($urandom);
            x.cyc  = 0;
            src_q[src].push_back(x);
        end
    endtask

    initial begin
        s_tvalid = '0;
        s_tlast  = '0;
        m_tready = 1'b0;
        for (int i = 0; i < NI; i++) begin
            s_tdata[i] = '0;
            s_tid[i]   = '0;
            s_tdest[i] = '0;
        end
        forever begin
            @(negedge clk);
            drv_acc = s_tvalid & s_tready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NI; i++) begin
                if (drv_acc[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
                if (src_q[i].size() == 0) begin
                    s_tvalid[i] = 1'b0;
                end else if (!(s_tvalid[i] && !drv_acc[i])) begin
                    // A presented beat is held until it is taken.
                    s_tvalid[i] = ($urandom_range(0, 99) < valid_pct);
                end
                if (src_q[i].size() != 0) begin
                    s_tdata[i] = src_q[i][0].data;
                    s_tlast[i] = src_q[i][0].last;
                    s_tid[i]   = src_q[i][0].tid;
                    s_tdest[i] = src_q[i][0].dest;
                end
            end
            m_tready = ($urandom_range(0, 99) < rdy_pct);
        end
    end

    // ---------------- reference model + per-cycle compare ----------------
    beat_t         mq[$];
    beat_t         out_log[$];
    beat_t         lb;
    int            m_owner  = -1;
    int            m_last   = NI - 1;
    int            m_grant  = 0;
    bit            m_valid  = 1'b0;
    bit            m_in_rst = 1'b0;
    int            cyc      = 0;
    logic [NI-1:0] exp_rdy;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (m_valid) begin
                exp_rdy = '0;
                if (m_owner >= 0 && mq.size() < 2) exp_rdy[m_owner] = 1'b1;
                check("s_tready", 64'(s_tready), 64'(exp_rdy));
                check("grant_idx", 64'(grant_idx), 64'(m_grant));
                check("m_tvalid", 64'(m_tvalid), 64'(mq.size() != 0));
                if (mq.size() != 0) begin
                    check("m_tdata", 64'(m_tdata), 64'(mq[0].data));
                    check("m_tlast", 64'(m_tlast), 64'(mq[0].last));
                    check("m_tid", 64'(m_tid), 64'(mq[0].tid));
                    check("m_tdest", 64'(m_tdest), 64'(mq[0].dest));
                end else if (m_in_rst) begin
                    check("rst_m_tdata", 64'(m_tdata), 64'(0));
                    check("rst_m_tlast", 64'(m_tlast), 64'(0));
                    check("rst_m_tid", 64'(m_tid), 64'(0));
                    check("rst_m_tdest", 64'(m_tdest), 64'(0));
                end
            end
            if (m_valid && !rst && m_tvalid === 1'b1 && m_tready === 1'b1) begin
                lb.data = m_tdata;
                lb.last = m_tlast;
                lb.tid  = m_tid;
                lb.dest = m_tdest;
                lb.cyc  = cyc;
                out_log.push_back(lb);
            end
            // Advance the model with the inputs the DUT samples at the next edge.
            if (rst) begin
                mq.delete();
                m_owner  = -1;
                m_last   = NI - 1;
                m_grant  = 0;
                m_valid  = 1'b1;
                m_in_rst = 1'b1;
            end else if (m_valid) begin
                bit    fire;
                bit    do_push;
                beat_t nb;
                m_in_rst = 1'b0;
                fire     = (mq.size() != 0) && m_tready;
                do_push  = 1'b0;
                if (m_owner < 0) begin
                    for (int k = 1; k <= NI; k++) begin
                        int c;
                        c = (m_last + k) % NI;
                        if (s_tvalid[c]) begin
                            m_owner = c;
                            m_last  = c;
                            m_grant = c;
                            break;
                        end
                    end
                end else if (mq.size() < 2 && s_tvalid[m_owner]) begin
                    nb.data = s_tdata[m_owner];
                    nb.last = s_tlast[m_owner];
`ifdef AXIS_PACKET_MUX_SRC_TAG_EN
                    nb.tid  = TIDW'(m_owner);
`else
                    nb.tid  = s_tid[m_owner];
`endif
                    nb.dest = s_tdest[m_owner];
                    nb.cyc  = 0;
                    do_push = 1'b1;
                    if (s_tlast[m_owner]) m_owner = -1;
                end
                if (fire) void'(mq.pop_front());
                if (do_push) mq.push_back(nb);
            end
        end
    end

    // ---------------- directed + random sequence ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_log(input int n, input int budget, input string name);
        int b;
        b = budget;
        while (out_log.size() < n && b > 0) begin
            tick();
            b--;
        end
        check(name, 64'(out_log.size() >= n), 64'(1));
    endtask

    task automatic drain(input int budget);
        int  b;
        bit  busy;
        b    = budget;
        busy = 1'b1;
        while (busy && b > 0) begin
            busy = (m_tvalid !== 1'b0);
            for (int i = 0; i < NI; i++) if (src_q[i].size() != 0) busy = 1'b1;
            if (busy) tick();
            b--;
        end
        check("drain_done", 64'(busy), 64'(0));
        repeat (3) tick();
    endtask

    int base;
    int total;
    int exp_tag3;

    initial begin
        rst = 1'b1;
        for (int i = 0; i < NI; i++) seq_cnt[i] = 0;
        for (int r = 0; r < 3; r++) for (int i = 0; i < NI; i++) load_pkt(i, 1, '0, 1'b0);
        repeat (3) tick();

        // Reset values with every source valid.
        check("rst_valid_in", 64'(s_tvalid), 64'(4'hf));
        check("rst_m_tvalid_lit", 64'(m_tvalid), 64'(0));
        check("rst_s_tready_lit", 64'(s_tready), 64'(0));
        check("rst_grant_lit", 64'(grant_idx), 64'(0));
        check("rst_m_tdata_lit", 64'(m_tdata), 64'(0));
        rst = 1'b0;
        tick();
        check("first_grant", 64'(grant_idx), 64'(0));
        check("first_ready", 64'(s_tready), 64'(4'b0001));

        // Fairness: single-beat packets from all sources.
        wait_log(12, 200, "fair_wait");
`ifdef AXIS_PACKET_MUX_SRC_TAG_EN
        exp_tag3 = 3;
`else
        exp_tag3 = 0;
`endif
        for (int k = 0; k < 12 && k < out_log.size(); k++) begin
            check("fair_src", 64'(out_log[k].data[31:24]), 64'(k % 4));
            check("fair_seq", 64'(out_log[k].data[23:0]), 64'(k / 4));
            if (k > 0) check("fair_gap", 64'(out_log[k].cyc - out_log[k-1].cyc), 64'(2));
            if (k % 4 == 3) check("src_tag", 64'(out_log[k].tid), 64'(exp_tag3));
        end
        drain(100);

        // Packet lock: 5-beat packet on 1 while 2 also waits.
        out_log.delete();
        base = seq_cnt[1];
        load_pkt(1, 5, '0, 1'b1);
        load_pkt(2, 1, '0, 1'b1);
        wait_log(6, 100, "lock_wait");
        for (int k = 0; k < 5 && k < out_log.size(); k++) begin
            check("lock_src", 64'(out_log[k].data[31:24]), 64'(1));
            check("lock_seq", 64'(out_log[k].data[23:0]), 64'(base + k));
            check("lock_last", 64'(out_log[k].last), 64'(k == 4));
            if (k > 0) check("lock_gap", 64'(out_log[k].cyc - out_log[k-1].cyc), 64'(1));
        end
        if (out_log.size() >= 6) check("lock_next_src", 64'(out_log[5].data[31:24]), 64'(2));
        drain(100);

        // Backpressure: 6 stalled cycles inside an 8-beat packet.
        out_log.delete();
        base = seq_cnt[0];
        load_pkt(0, 8, '0, 1'b1);
        wait_log(2, 100, "bp_wait");
        rdy_pct = 0;
        repeat (3) tick();
        check("bp_ready_low", 64'(s_tready), 64'(0));
        check("bp_m_tvalid", 64'(m_tvalid), 64'(1));
        repeat (3) tick();
        check("bp_ready_low2", 64'(s_tready), 64'(0));
        rdy_pct = 100;
        wait_log(8, 100, "bp_resume");
        repeat (4) tick();
        check("bp_count", 64'(out_log.size()), 64'(8));
        for (int k = 0; k < 8 && k < out_log.size(); k++) begin
            check("bp_seq", 64'(out_log[k].data[23:0]), 64'(base + k));
        end
        drain(100);

        // Reset pulse at beat 3, then arbitration restarts from input 0.
        out_log.delete();
        load_pkt(2, 6, '0, 1'b1);
        wait_log(3, 100, "mrst_wait");
        rst = 1'b1;
        load_pkt(1, 1, '0, 1'b1);
        load_pkt(3, 1, '0, 1'b1);
        tick();
        rst = 1'b0;
        check("mrst_m_tvalid", 64'(m_tvalid), 64'(0));
        check("mrst_ready", 64'(s_tready), 64'(0));
        check("mrst_grant0", 64'(grant_idx), 64'(0));
        tick();
        check("mrst_next_grant", 64'(grant_idx), 64'(1));
        check("mrst_next_ready", 64'(s_tready), 64'(4'b0010));
        drain(200);

        // Random traffic and backpressure.
        out_log.delete();
        total     = 0;
        valid_pct = 60;
        rdy_pct   = 70;
        for (int p = 0; p < 40; p++) begin
            int len;
            len = $urandom_range(1, 6);
            load_pkt($urandom_range(0, NI - 1), len, '0, 1'b1);
            total += len;
        end
        drain(3000);
        rdy_pct   = 100;
        valid_pct = 100;
        repeat (5) tick();
        check("rand_beats", 64'(out_log.size()), 64'(total));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
